// File: rtl/adc_ram_readout_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_ram_readout_if
// Valid/ready stream that carries accumulated RAM words to the host-side logic.
//   m_data   word payload (driven by master)
//   m_valid  payload valid (driven by master)
//   m_last   final word of a readout run (driven by master)
//   m_ready  downstream accept (driven by slave)
// Revision: 1.0
// ---------------------------------------------------------------------------
interface adc_ram_readout_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface
`default_nettype wire

// File: rtl/adc_ram_readout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_ram_readout
// Streams words 0..len-1 of the accumulation RAM (port B) over a valid/ready
// interface, each word logically right-shifted by SHIFT. Optionally zeroes
// the read span afterwards (compile-time macro ADC_READOUT_CLEAR_EN).
//
// Ports:
//   clk            capture clock
//   rst            asynchronous active-high reset
//   i_start        one-cycle launch pulse, ignored while busy
//   i_rd_len       word count (clamped to 2^ADDR_W), sampled on start
//   o_busy         readout or clear in progress
//   o_done         one-cycle completion pulse
//   o_ram_addr     RAM port B address
//   i_ram_rd_data  RAM port B read data (one cycle after address)
//   o_ram_we       RAM port B write enable (clear pass only)
//   o_ram_wr_data  RAM port B write data (always zero)
//   m_axis         output stream (master modport)
// Revision: 1.0
// ---------------------------------------------------------------------------
module adc_ram_readout #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int SHIFT  = 0
) (
  input  wire                 clk,
  input  wire                 rst,
  input  wire                 i_start,
  input  wire  [ADDR_W:0]     i_rd_len,
  output logic                o_busy,
  output logic                o_done,
  output logic [ADDR_W-1:0]   o_ram_addr,
  input  wire  [DATA_W-1:0]   i_ram_rd_data,
  output logic                o_ram_we,
  output logic [DATA_W-1:0]   o_ram_wr_data,
  adc_ram_readout_if.master   m_axis
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
`ifdef ADC_READOUT_CLEAR_EN
  localparam logic [1:0] S_CLEAR  = 2'd2;
`endif
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [ADDR_W:0] c_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_addr;       // one bit wider so len = 2^ADDR_W terminates cleanly
  logic              r_rvld;       // a read was issued last cycle; data arrives now
  logic              r_rlast;      // that read was for word len-1
  logic [DATA_W-1:0] r_fifo_data [0:1];
  logic              r_fifo_last [0:1];
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;

  logic [ADDR_W:0]   w_len_clamp;
  logic              w_start;
  logic              w_pop;
  logic              w_room;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_last_hs;

  assign w_len_clamp = (i_rd_len > c_MAX_LEN) ? c_MAX_LEN : i_rd_len;
  assign w_start     = (r_state == S_IDLE) && i_start;
  assign w_pop       = (r_cnt != 2'd0) && m_axis.m_ready;

  // A new read may only be issued if, after this cycle's pop and the capture
  // of the read already in flight, at most one FIFO slot is taken. Counting
  // the pop keeps the stream at one word per cycle under full throughput.
  assign w_room       = ({1'b0, r_cnt} + {2'b00, r_rvld}) < (3'd2 + {2'b00, w_pop});
  assign w_issue      = (r_state == S_READ) && (r_addr < r_len) && w_room;
  assign w_issue_last = w_issue && (r_addr == r_len - 1'b1);
  assign w_last_hs    = w_pop && r_fifo_last[r_rp];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = S_READ;
      end
      S_READ: begin
        // A zero-length run spends one empty READ cycle, so done lands two
        // cycles after the start edge.
        if (r_len == '0) begin
          w_state_next = S_FINISH;
        end else if (w_last_hs) begin
`ifdef ADC_READOUT_CLEAR_EN
          w_state_next = S_CLEAR;
`else
          w_state_next = S_FINISH;
`endif
        end
      end
`ifdef ADC_READOUT_CLEAR_EN
      S_CLEAR: begin
        if (r_addr == r_len - 1'b1) w_state_next = S_FINISH;
      end
`endif
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Address counter, read tracking and 2-entry output FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len          <= '0;
      r_addr         <= '0;
      r_rvld         <= 1'b0;
      r_rlast        <= 1'b0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_wp           <= 1'b0;
      r_rp           <= 1'b0;
      r_cnt          <= 2'd0;
    end else begin
      if (w_start) begin
        r_len  <= w_len_clamp;
        r_addr <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + 1'b1;
`ifdef ADC_READOUT_CLEAR_EN
      end else if ((r_state == S_READ) && w_last_hs) begin
        r_addr <= '0;               // clear pass restarts at address 0
      end else if (r_state == S_CLEAR) begin
        r_addr <= r_addr + 1'b1;
`endif
      end else if (r_state == S_FINISH) begin
        r_addr <= '0;
      end

      r_rvld  <= w_issue;
      r_rlast <= w_issue_last;

      if (r_rvld) begin
        r_fifo_data[r_wp] <= i_ram_rd_data >> SHIFT;
        r_fifo_last[r_wp] <= r_rlast;
        r_wp              <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + {1'b0, r_rvld} - {1'b0, w_pop};
    end
  end

  // Outputs
  always_comb begin
    o_busy          = (r_state != S_IDLE);
    o_done          = (r_state == S_FINISH);
    o_ram_addr      = r_addr[ADDR_W-1:0];
    o_ram_wr_data   = '0;
`ifdef ADC_READOUT_CLEAR_EN
    o_ram_we        = (r_state == S_CLEAR);
`else
    o_ram_we        = 1'b0;
`endif
    m_axis.m_data   = r_fifo_data[r_rp];
    m_axis.m_valid  = (r_cnt != 2'd0);
    m_axis.m_last   = (r_cnt != 2'd0) && r_fifo_last[r_rp];
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_ram_readout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_adc_ram_readout
// Self-checking bench: table of readout runs against a behavioural RAM,
// expected words queued at start and compared on each handshake, plus
// hand-written reset, shift and mid-run-start sequences.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_adc_ram_readout;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
`ifdef ADC_READOUT_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT 1 (SHIFT = 0)
  logic              start = 1'b0;
  logic [ADDR_W:0]   rd_len = '0;
  logic              busy, done, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rd, ram_wr;
  adc_ram_readout_if #(.DATA_W(DATA_W)) bus ();

  adc_ram_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_rd_len(rd_len),
    .o_busy(busy), .o_done(done), .o_ram_addr(ram_addr),
    .i_ram_rd_data(ram_rd), .o_ram_we(ram_we), .o_ram_wr_data(ram_wr),
    .m_axis(bus.master)
  );

  // DUT 2 (SHIFT = 4)
  logic              start2 = 1'b0;
  logic [ADDR_W:0]   rd_len2 = '0;
  logic              busy2, done2, ram_we2;
  logic [ADDR_W-1:0] ram_addr2;
  logic [DATA_W-1:0] ram_rd2, ram_wr2;
  adc_ram_readout_if #(.DATA_W(DATA_W)) bus2 ();

  adc_ram_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SHIFT(4)) dut2 (
    .clk(clk), .rst(rst), .i_start(start2), .i_rd_len(rd_len2),
    .o_busy(busy2), .o_done(done2), .o_ram_addr(ram_addr2),
    .i_ram_rd_data(ram_rd2), .o_ram_we(ram_we2), .o_ram_wr_data(ram_wr2),
    .m_axis(bus2.master)
  );

  // Behavioural RAMs (synchronous read)
  logic [DATA_W-1:0] ram [0:4095];
  logic              load = 1'b0;
  logic [15:0]       seed_v = '0;

  function automatic logic [31:0] pat(input int i, input logic [15:0] s);
    return 32'(i * 3) ^ {s, 16'h0000};
  endfunction

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 4096; i++) ram[i] <= pat(i, seed_v);
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wr;
    end
    ram_rd <= ram[ram_addr];
  end

  always @(posedge clk) ram_rd2 <= (ram_addr2 == '0) ? 32'hFFFF_FFF0 : 32'h0;

  int checks = 0;
  int errors = 0;
  logic [DATA_W:0] sbq [$];   // {last, data}

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] s);
    @(posedge clk); #1;
    seed_v = s; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic run(input int len_in, input int exp_n, input int pct, input bit poke);
    int k, hs, first_v, exp_done;
    bit stalled, got_done;
    logic [DATA_W-1:0] held;
    logic [DATA_W:0] e;
    for (int i = 0; i < exp_n; i++) sbq.push_back({(i == exp_n - 1), pat(i, seed_v)});
    exp_done = (exp_n == 0) ? 2 : (CLR ? 3 + 2 * exp_n : 3 + exp_n);
    start = 1'b1; rd_len = len_in[ADDR_W:0];
    @(posedge clk); #1;
    start = 1'b0;
    k = 1; hs = 0; first_v = 0; stalled = 1'b0; got_done = 1'b0; held = '0;
    chk("busy_t1", busy, 1);
    chk("addr_t1", ram_addr, 0);
    while (!got_done && k < 20000) begin
      bus.m_ready = ($urandom_range(0, 99) < pct);
      if (poke && k == 5) begin start = 1'b1; rd_len = 13'd7; end
      else start = 1'b0;
      if (bus.m_valid && first_v == 0) begin
        first_v = k;
        if (pct == 100) chk("first_valid_cycle", k, 3);
      end
      if (stalled) chk("stall_hold", bus.m_data, held);
      if (bus.m_valid && bus.m_ready) begin
        if (sbq.size() == 0) begin
          chk("word_count", hs + 1, exp_n);
        end else begin
          e = sbq.pop_front();
          chk("data", bus.m_data, e[DATA_W-1:0]);
          chk("last", bus.m_last, e[DATA_W]);
          if (pct == 100) chk("hs_cycle", k, 3 + hs);
        end
        hs++;
      end
      stalled = bus.m_valid && !bus.m_ready;
      held = bus.m_data;
      if (done) begin
        got_done = 1'b1;
        chk("done_words", hs, exp_n);
        if (pct == 100) chk("done_cycle", k, exp_done);
        chk("busy_at_done", busy, 1);
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    bus.m_ready = 1'b1;
    chk("done_seen", got_done, 1);
    chk("busy_after", busy, 0);
    chk("done_one_cycle", done, 0);
    if (exp_n > 0) begin
      chk("ram_span_first", ram[0], CLR ? 32'h0 : pat(0, seed_v));
      chk("ram_span_last", ram[exp_n - 1], CLR ? 32'h0 : pat(exp_n - 1, seed_v));
    end
    if (exp_n < 4096) chk("ram_beyond", ram[exp_n], pat(exp_n, seed_v));
    sbq.delete();
  endtask

  typedef struct {
    int         len_in;
    int         exp_n;
    int         pct;
    bit         poke;
    logic [15:0] seed;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int k, hs;
    vecs[0] = '{len_in: 4096, exp_n: 4096, pct: 100, poke: 1'b0, seed: 16'h0000};
    vecs[1] = '{len_in: 16,   exp_n: 16,   pct: 50,  poke: 1'b0, seed: 16'h0011};
    vecs[2] = '{len_in: 0,    exp_n: 0,    pct: 100, poke: 1'b0, seed: 16'h0022};
    vecs[3] = '{len_in: 5000, exp_n: 4096, pct: 100, poke: 1'b0, seed: 16'h0033};
    vecs[4] = '{len_in: 8,    exp_n: 8,    pct: 100, poke: 1'b1, seed: 16'h0044};
    vecs[5] = '{len_in: 3,    exp_n: 3,    pct: 40,  poke: 1'b0, seed: 16'h0055};

    bus.m_ready  = 1'b1;
    bus2.m_ready = 1'b1;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_last", bus.m_last, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_we", ram_we, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      preload(vecs[v].seed);
      run(vecs[v].len_in, vecs[v].exp_n, vecs[v].pct, vecs[v].poke);
    end

    // SHIFT = 4 single-word run
    @(posedge clk); #1;
    start2 = 1'b1; rd_len2 = 13'd1;
    @(posedge clk); #1;
    start2 = 1'b0;
    k = 1; hs = 0;
    while (k < 20) begin
      if (bus2.m_valid) begin
        chk("shift_data", bus2.m_data, 32'h0FFF_FFFF);
        chk("shift_last", bus2.m_last, 1);
        chk("shift_valid_cycle", k, 3);
      end
      if (done2) begin
        hs = 1;
        chk("shift_done_cycle", k, CLR ? 5 : 4);
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    chk("shift_done_seen", hs, 1);

    // Reset after the 5th of 10 words, then a clean rerun
    preload(16'h0066);
    start = 1'b1; rd_len = 13'd10;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0; k = 1;
    while (hs < 5 && k < 100) begin
      if (bus.m_valid && bus.m_ready) hs++;
      if (hs < 5) begin @(posedge clk); #1; k++; end
    end
    chk("mid_hs_count", hs, 5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_addr", ram_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(10, 10, 100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
